// File: rtl/gray_pkg.sv
// gray_pkg: Gray-code helpers, pointer-width helper and controller state type.
package gray_pkg;
  localparam int GRAY_MAX_W = 32;
  typedef enum logic {INIT, RUN} ctrl_state_t;
  function automatic int ptr_width(input int addr_w);
    return addr_w + 1;
  endfunction
  // Callers zero-extend to GRAY_MAX_W and truncate the result to their own width.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = g;
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray_sync.sv
// gray_sync: STAGES-deep flop-chain synchroniser with asynchronous clear.
module gray_sync #(
  parameter int WIDTH = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES*WIDTH-1:0] chain;
  always_ff @(posedge clk or posedge aclr)
    if (aclr) chain <= '0;
    else chain <= {chain[(STAGES-1)*WIDTH-1:0], d};
  assign q = chain[STAGES*WIDTH-1 -: WIDTH];
endmodule

// File: rtl/gray_wptr_ctrl.sv
// gray_wptr_ctrl: write-side Gray pointer controller for an async FIFO.
// Define GRAY_WPTR_CHECK_EN to enable the synchronised read-pointer Gray-step checker.
module gray_wptr_ctrl
  import gray_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_THRESH = 12
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              wr_req,
  output logic              wr_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W:0]   wptr_gray,
  input  logic [ADDR_W:0]   rptr_gray_async,
  output logic              full,
  output logic              afull,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  input  logic              clr_err,
  output logic              gray_err
);
  localparam int PW = ptr_width(ADDR_W);
  localparam int GW = GRAY_MAX_W;
  localparam int CW = $clog2(SYNC_STAGES + 1);
  ctrl_state_t state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] wbin, wbin_next, wg_next, rq_sync, level_next;
  logic go_run, full_next;
  gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_rsync (
    .clk(clk), .aclr(aclr), .d(rptr_gray_async), .q(rq_sync)
  );
  assign wr_ack = wr_req & ~full & (state == RUN);
  assign mem_we = wr_ack;
  assign wr_addr = wbin[ADDR_W-1:0];
  assign wbin_next = wbin + PW'(wr_ack);
  assign wg_next = PW'(bin2gray(GW'(wbin_next)));
  assign full_next = wg_next == {~rq_sync[ADDR_W:ADDR_W-1], rq_sync[ADDR_W-2:0]};
  assign level_next = PW'(GW'(wbin_next) - gray2bin(GW'(rq_sync)));
  // full is released on the same edge that leaves INIT
  assign go_run = (state == RUN) || (cnt == CW'(SYNC_STAGES));
  always_ff @(posedge clk or posedge aclr)
    if (aclr) begin
      state <= INIT;
      cnt <= '0;
      wbin <= '0;
      wptr_gray <= '0;
      full <= 1'b1;
      afull <= 1'b0;
      level <= '0;
      overflow <= 1'b0;
    end else begin
      state <= go_run ? RUN : INIT;
      cnt <= (state == RUN) ? cnt : cnt + 1'b1;
      wbin <= wbin_next;
      wptr_gray <= wg_next;
      full <= go_run ? full_next : 1'b1;
      afull <= level_next >= PW'(AFULL_THRESH);
      level <= level_next;
      overflow <= (wr_req & full & (state == RUN)) | (overflow & ~clr_err);
    end
`ifdef GRAY_WPTR_CHECK_EN
  logic [PW-1:0] rq_prev, rq_diff;
  assign rq_diff = rq_sync ^ rq_prev;
  always_ff @(posedge clk or posedge aclr)
    if (aclr) begin
      rq_prev <= '0;
      gray_err <= 1'b0;
    end else begin
      rq_prev <= rq_sync;
      gray_err <= (|(rq_diff & (rq_diff - PW'(1)))) | (gray_err & ~clr_err);
    end
`else
  assign gray_err = 1'b0;
`endif
endmodule
